// File: rtl/bs_pkg.sv
// Shared types and helpers for the bitstream packer.
package bs_pkg;

  localparam int BS_DATA_WD = 32;
  localparam int BS_NUMB_WD = $clog2(BS_DATA_WD);
  localparam int BS_BCNT_WD = BS_NUMB_WD - 2;

  // Wide enough for any legal DATA_WD; callers truncate to their own width.
  localparam int MASK_WD = 128;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  function automatic logic [MASK_WD-1:0] bs_mask(input int unsigned n);
    return (MASK_WD'(1) << n) - MASK_WD'(1);
  endfunction

endpackage

// File: rtl/bs_pack_if.sv
// Code-input / word-output handshake bundle of the bitstream packer.
interface bs_pack_if #(
  parameter int DATA_WD = bs_pkg::BS_DATA_WD
);
  localparam int NUMB_WD = $clog2(DATA_WD);
  localparam int BCNT_WD = NUMB_WD - 2;

  logic               val_i;
  logic [DATA_WD-1:0] dat_i;
  logic [NUMB_WD-1:0] numb_i;
  logic               flush_i;
  logic               rdy_o;
  logic               val_o;
  logic [DATA_WD-1:0] dat_o;
  logic [BCNT_WD-1:0] bcnt_o;
  logic               last_o;
  logic               rdy_i;
  logic               done_o;

  modport master (
    output val_i, dat_i, numb_i, flush_i, rdy_i,
    input  rdy_o, val_o, dat_o, bcnt_o, last_o, done_o
  );

  modport slave (
    input  val_i, dat_i, numb_i, flush_i, rdy_i,
    output rdy_o, val_o, dat_o, bcnt_o, last_o, done_o
  );

endinterface

// File: rtl/bs_pack_align.sv
// Combinational merge of a new code into the accumulator and realignment
// after a full word is peeled off, for either bit order.
module bs_pack_align #(
  parameter int DATA_WD   = 32,
  parameter bit LSB_FIRST = 1'b1,
  parameter int NUMB_WD   = $clog2(DATA_WD),
  parameter int TOT_WD    = NUMB_WD + 1
) (
  input  logic [2*DATA_WD-1:0] acc,
  input  logic [NUMB_WD-1:0]   cnt,
  input  logic [DATA_WD-1:0]   dat,
  input  logic [TOT_WD-1:0]    n,
  output logic [DATA_WD-1:0]   word,
  output logic [DATA_WD-1:0]   tail,
  output logic [2*DATA_WD-1:0] acc_nxt,
  output logic [NUMB_WD-1:0]   cnt_nxt,
  output logic                 full
);
  localparam int SH_WD = NUMB_WD + 2;

  logic [TOT_WD-1:0]    total;
  logic [SH_WD-1:0]     sh_msb;
  logic [2*DATA_WD-1:0] ext;
  logic [2*DATA_WD-1:0] combined;

  assign total    = TOT_WD'(cnt) + n;
  assign full     = total >= TOT_WD'(DATA_WD);
  assign sh_msb   = SH_WD'(2*DATA_WD) - SH_WD'(cnt) - SH_WD'(n);
  assign ext      = {{DATA_WD{1'b0}}, dat};
  assign combined = LSB_FIRST ? (acc | (ext << cnt)) : (acc | (ext << sh_msb));

  assign word = LSB_FIRST ? combined[DATA_WD-1:0] : combined[2*DATA_WD-1:DATA_WD];

  // Bits outside the valid region are always zero, so the flush word is
  // already zero-padded.
  assign tail = LSB_FIRST ? acc[DATA_WD-1:0] : acc[2*DATA_WD-1:DATA_WD];

  always_comb begin
    acc_nxt = combined;
    cnt_nxt = NUMB_WD'(total);
    if (full) begin
      acc_nxt = LSB_FIRST ? (combined >> DATA_WD) : (combined << DATA_WD);
      cnt_nxt = NUMB_WD'(total - TOT_WD'(DATA_WD));
    end
  end

endmodule

// File: rtl/bs_pack.sv
// Bitstream packer: variable-length codes into DATA_WD-bit words with
// selectable bit order, backpressure and zero-padded flush.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_RUN   | accepting codes/flush whenever the output slot can take a word
//   S_FLUSH | residual bits waiting for a free slot to go out as last word
module bs_pack
  import bs_pkg::*;
#(
  parameter int DATA_WD   = BS_DATA_WD,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rstn,
  bs_pack_if.slave bus
);
  localparam int NUMB_WD = $clog2(DATA_WD);
  localparam int BCNT_WD = NUMB_WD - 2;
  localparam int TOT_WD  = NUMB_WD + 1;
  localparam logic [BCNT_WD-1:0] BCNT_FULL = BCNT_WD'(DATA_WD/8 - 1);

  state_e               state;
  logic [2*DATA_WD-1:0] acc;
  logic [NUMB_WD-1:0]   cnt;

  logic                 slot_free;
  logic                 accept;
  logic                 flush_acc;
  logic [TOT_WD-1:0]    n;
  logic [DATA_WD-1:0]   dat_m;
  logic [DATA_WD-1:0]   word;
  logic [DATA_WD-1:0]   tail;
  logic [2*DATA_WD-1:0] acc_nxt;
  logic [NUMB_WD-1:0]   cnt_nxt;
  logic                 full;
  logic [NUMB_WD-1:0]   rem_cnt;

  assign slot_free = !bus.val_o || bus.rdy_i;
  assign bus.rdy_o = (state == S_RUN) && slot_free;
  assign accept    = bus.val_i && bus.rdy_o;
  assign flush_acc = bus.flush_i && bus.rdy_o;
  assign n         = TOT_WD'(bus.numb_i) + TOT_WD'(1);
  assign dat_m     = DATA_WD'(MASK_WD'(bus.dat_i) & bs_mask(32'(n)));
  assign rem_cnt   = accept ? cnt_nxt : cnt;

  bs_pack_align #(
    .DATA_WD   (DATA_WD),
    .LSB_FIRST (LSB_FIRST),
    .NUMB_WD   (NUMB_WD),
    .TOT_WD    (TOT_WD)
  ) u_align (
    .acc     (acc),
    .cnt     (cnt),
    .dat     (dat_m),
    .n       (n),
    .word    (word),
    .tail    (tail),
    .acc_nxt (acc_nxt),
    .cnt_nxt (cnt_nxt),
    .full    (full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_RUN;
      acc        <= '0;
      cnt        <= '0;
      bus.val_o  <= 1'b0;
      bus.dat_o  <= '0;
      bus.bcnt_o <= '0;
      bus.last_o <= 1'b0;
      bus.done_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      if (bus.val_o && bus.rdy_i) begin
        bus.val_o  <= 1'b0;
        bus.dat_o  <= '0;
        bus.bcnt_o <= '0;
        bus.last_o <= 1'b0;
      end
      case (state)
        S_RUN: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (full) begin
              bus.val_o  <= 1'b1;
              bus.dat_o  <= word;
              bus.bcnt_o <= BCNT_FULL;
              bus.last_o <= flush_acc && (cnt_nxt == '0);
            end
          end
          if (flush_acc) begin
            // Empty remainder finishes now; otherwise the tail needs a slot.
            if (rem_cnt == '0) bus.done_o <= 1'b1;
            else               state      <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (slot_free) begin
            bus.val_o  <= 1'b1;
            bus.dat_o  <= tail;
            bus.bcnt_o <= BCNT_WD'((cnt - 1'b1) >> 3);
            bus.last_o <= 1'b1;
            bus.done_o <= 1'b1;
            acc        <= '0;
            cnt        <= '0;
            state      <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_pack.sv
// Directed bench for bs_pack: vector table on an LSB-first instance plus
// hand-written backpressure, MSB-first and reset sequences.
module tb_bs_pack;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bs_pack_if #(.DATA_WD(32)) bl ();
  bs_pack_if #(.DATA_WD(32)) bm ();

  bs_pack #(.DATA_WD(32), .LSB_FIRST(1'b1)) dut_lsb (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bl.slave)
  );

  bs_pack #(.DATA_WD(32), .LSB_FIRST(1'b0)) dut_msb (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bm.slave)
  );

  typedef struct {
    logic        val;
    logic [31:0] dat;
    logic [4:0]  numb;
    logic        flush;
    logic        rdy;
    logic        oval;
    logic [31:0] odat;
    logic [2:0]  obcnt;
    logic        olast;
    logic        odone;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present a code on the LSB instance and hold it until accepted.
  task automatic send_lsb(input logic [31:0] d, input logic [4:0] nb, input logic fl);
    int t;
    bl.val_i = 1'b1; bl.dat_i = d; bl.numb_i = nb; bl.flush_i = fl;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bl.rdy_o && t < 200);
    chk("send accept timeout", {31'd0, bl.rdy_o}, 32'd1);
    @(posedge clk); #1;
    bl.val_i = 1'b0; bl.flush_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenarios 1-3, masking, exact-fill and W-bit code at cnt=W-1, zero-residual flush.
    //            val dat           nb  fl rdy  oval odat          bc lst dn
    vt[0]  = '{1'b1, 32'h00000409, 5'd15, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'h09040409, 5'd31, 1'b0, 1'b1, 1'b1, 32'h04090409, 3'd3, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 32'h0000000F, 5'd3,  1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 32'h0000ABCD, 5'd15, 1'b0, 1'b1, 1'b1, 32'hBCDF0904, 3'd3, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b1, 32'h0000000A, 3'd0, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 32'h00001234, 5'd15, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 32'h00005678, 5'd15, 1'b1, 1'b1, 1'b1, 32'h56781234, 3'd3, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1};
    vt[11] = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 32'hFFFFFFFF, 5'd3,  1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 32'hFFFFFFF0, 5'd27, 1'b0, 1'b1, 1'b1, 32'hFFFFFF0F, 3'd3, 1'b0, 1'b0};
    vt[14] = '{1'b1, 32'h7FFFFFFF, 5'd30, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 32'h80000001, 5'd31, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 3'd3, 1'b0, 1'b0};
    vt[16] = '{1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    vt[17] = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b1, 32'h40000000, 3'd3, 1'b1, 1'b1};
    vt[18] = '{1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};

    bl.val_i = 1'b0; bl.dat_i = '0; bl.numb_i = '0; bl.flush_i = 1'b0; bl.rdy_i = 1'b1;
    bm.val_i = 1'b0; bm.dat_i = '0; bm.numb_i = '0; bm.flush_i = 1'b0; bm.rdy_i = 1'b1;

    #12;
    chk("reset val_o",  {31'd0, bl.val_o},  32'd0);
    chk("reset dat_o",  bl.dat_o,           32'd0);
    chk("reset bcnt_o", {29'd0, bl.bcnt_o}, 32'd0);
    chk("reset last_o", {31'd0, bl.last_o}, 32'd0);
    chk("reset done_o", {31'd0, bl.done_o}, 32'd0);
    chk("reset msb val_o", {31'd0, bm.val_o}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      bl.val_i = vt[i].val; bl.dat_i = vt[i].dat; bl.numb_i = vt[i].numb; bl.flush_i = vt[i].flush;
      #1;
      chk($sformatf("v%0d rdy_o", i), {31'd0, bl.rdy_o}, {31'd0, vt[i].rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d val_o", i),  {31'd0, bl.val_o},  {31'd0, vt[i].oval});
      chk($sformatf("v%0d done_o", i), {31'd0, bl.done_o}, {31'd0, vt[i].odone});
      if (vt[i].oval) begin
        chk($sformatf("v%0d dat_o", i),  bl.dat_o, vt[i].odat);
        chk($sformatf("v%0d bcnt_o", i), {29'd0, bl.bcnt_o}, {29'd0, vt[i].obcnt});
        chk($sformatf("v%0d last_o", i), {31'd0, bl.last_o}, {31'd0, vt[i].olast});
      end
    end
    bl.val_i = 1'b0; bl.flush_i = 1'b0;

    // Backpressure: word held for 5 cycles while the next beat waits.
    bl.rdy_i = 1'b0;
    send_lsb(32'h11111111, 5'd31, 1'b0);
    chk("bp first word", bl.dat_o, 32'h11111111);
    bl.val_i = 1'b1; bl.dat_i = 32'h22222222; bl.numb_i = 5'd31;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d val_o", c), {31'd0, bl.val_o}, 32'd1);
      chk($sformatf("bp hold%0d dat_o", c), bl.dat_o, 32'h11111111);
      chk($sformatf("bp hold%0d rdy_o", c), {31'd0, bl.rdy_o}, 32'd0);
    end
    @(posedge clk); #1;
    bl.rdy_i = 1'b1;
    #1;
    chk("bp release rdy_o", {31'd0, bl.rdy_o}, 32'd1);
    @(posedge clk); #1;
    bl.val_i = 1'b0;
    bl.rdy_i = 1'b0;
    chk("bp second word", bl.dat_o, 32'h22222222);
    chk("bp second val", {31'd0, bl.val_o}, 32'd1);

    // Continuous full-width codes under random downstream ready.
    fork
      begin
        for (int k = 0; k < 8; k++) send_lsb(32'hFFFFFFFF, 5'd31, 1'b0);
      end
      begin
        int got;
        int cyc;
        logic [31:0] expw;
        got = 0; cyc = 0;
        while (got < 9 && cyc < 400) begin
          @(posedge clk); #2;
          bl.rdy_i = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (bl.val_o && bl.rdy_i) begin
            expw = (got == 0) ? 32'h22222222 : 32'hFFFFFFFF;
            chk($sformatf("stream word%0d", got), bl.dat_o, expw);
            got++;
          end
          cyc++;
        end
        chk("stream word count", got, 9);
      end
    join
    @(posedge clk); #1;
    chk("stream drained val_o", {31'd0, bl.val_o}, 32'd0);
    bl.rdy_i = 1'b1;

    // MSB-first: two nibbles then flush.
    bm.val_i = 1'b1; bm.dat_i = 32'hA; bm.numb_i = 5'd3;
    @(posedge clk); #1;
    bm.dat_i = 32'hB;
    @(posedge clk); #1;
    bm.val_i = 1'b0; bm.flush_i = 1'b1;
    #1;
    chk("msb flush rdy_o", {31'd0, bm.rdy_o}, 32'd1);
    @(posedge clk); #1;
    bm.flush_i = 1'b0;
    chk("msb in flush rdy_o", {31'd0, bm.rdy_o}, 32'd0);
    @(posedge clk); #1;
    chk("msb val_o",  {31'd0, bm.val_o},  32'd1);
    chk("msb dat_o",  bm.dat_o,           32'hAB000000);
    chk("msb bcnt_o", {29'd0, bm.bcnt_o}, 32'd0);
    chk("msb last_o", {31'd0, bm.last_o}, 32'd1);
    chk("msb done_o", {31'd0, bm.done_o}, 32'd1);
    @(posedge clk); #1;

    // MSB word plus residual, held in S_FLUSH, then reset.
    bm.val_i = 1'b1; bm.dat_i = 32'h5; bm.numb_i = 5'd3;
    @(posedge clk); #1;
    bm.dat_i = 32'hFFFFFFFF; bm.numb_i = 5'd31; bm.flush_i = 1'b1;
    @(posedge clk); #1;
    bm.val_i = 1'b0; bm.flush_i = 1'b0; bm.rdy_i = 1'b0;
    chk("msb word2 dat_o",  bm.dat_o, 32'h5FFFFFFF);
    chk("msb word2 last_o", {31'd0, bm.last_o}, 32'd0);
    chk("msb word2 done_o", {31'd0, bm.done_o}, 32'd0);
    @(posedge clk); #1;
    chk("msb flush held rdy_o", {31'd0, bm.rdy_o}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("rst val_o",  {31'd0, bm.val_o},  32'd0);
    chk("rst dat_o",  bm.dat_o,           32'd0);
    chk("rst bcnt_o", {29'd0, bm.bcnt_o}, 32'd0);
    chk("rst last_o", {31'd0, bm.last_o}, 32'd0);
    chk("rst done_o", {31'd0, bm.done_o}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bm.rdy_i = 1'b1;
    @(posedge clk); #1;
    bm.flush_i = 1'b1;
    #1;
    chk("post rst rdy_o", {31'd0, bm.rdy_o}, 32'd1);
    @(posedge clk); #1;
    bm.flush_i = 1'b0;
    chk("post rst flush val_o",  {31'd0, bm.val_o},  32'd0);
    chk("post rst flush done_o", {31'd0, bm.done_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bs_pack.md
Name: bs_pack

Overview:
- Parametrised bitstream packer: concatenates variable-length codes (1..DATA_WD bits per beat) into DATA_WD-bit words for the PNG/deflate output path.
- Successor to the fixed 32-bit concatenator. Adds:
  - selectable bit order (LSB-first for deflate, MSB-first for header/CRC fields);
  - downstream backpressure;
  - explicit flush with zero padding, valid-byte count and last-word marking.
- Sits between the Huffman/LZ77 code emitters and the byte/word writer.

Parameters:
- DATA_WD, 32: input code width and output word width; multiple of 8, ≥16.
- NUMB_WD, $clog2(DATA_WD) = 5: width of numb_i.
- LSB_FIRST, 1: 1 = first code at bit 0 (deflate order); 0 = first code at MSB.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- val_i  in  1  input code valid
- dat_i  in  DATA_WD  code bits, right-aligned; bits above numb_i are ignored (masked)
- numb_i  in  NUMB_WD  code length minus 1 (0 → 1 bit, DATA_WD-1 → DATA_WD bits)
- flush_i  in  1  qualified by rdy_o; flush after this beat's code (if val_i) or after existing bits
- rdy_o  out  1  input/flush accepted this cycle when high
- val_o  out  1  output word valid
- dat_o  out  DATA_WD  packed word
- bcnt_o  out  NUMB_WD-2  valid bytes minus 1 in dat_o (DATA_WD/8-1 for every non-last word)
- last_o  out  1  final word of a flush
- rdy_i  in  1  downstream ready
- done_o  out  1  one-cycle pulse when a flush completes

Behaviour:
- Reset (async assert, sync deassert by the source):
  - outputs: val_o=0, dat_o=0, bcnt_o=0, last_o=0, done_o=0;
  - internal: accumulator=0, cnt=0, state=S_RUN.
- State: accumulator acc of 2*DATA_WD bits; fill count cnt, invariant cnt<DATA_WD at every cycle boundary in S_RUN.
- Output slot (val_o/dat_o/bcnt_o/last_o) is a register. It holds stable while val_o & !rdy_i, and clears on val_o & rdy_i unless reloaded in the same cycle.
- rdy_o = (state==S_RUN) & (!val_o | rdy_i).
- Accept (val_i & rdy_o):
  - n = numb_i+1; total = cnt+n.
  - LSB_FIRST=1: combined = acc | (masked dat << cnt).
  - LSB_FIRST=0: combined = acc | (masked dat << (2*DATA_WD - cnt - n)).
- If total ≥ DATA_WD:
  - next cycle val_o=1, bcnt_o=DATA_WD/8-1, last_o=0;
  - dat_o = combined[DATA_WD-1:0] (LSB) or combined[2W-1:W] (MSB);
  - acc = remaining bits realigned; cnt = total-DATA_WD.
  - Latency 1 cycle from the completing beat.
- If total < DATA_WD: acc=combined, cnt=total, no output.
- Flush accepted (flush_i & rdy_o), evaluated after the same-cycle code:
  - remaining cnt' == 0, and the same-cycle word was emitted: that word gets last_o=1; done_o pulses with it; stay in S_RUN.
  - remaining cnt' == 0, and no word was emitted: no output; done_o pulses next cycle; stay in S_RUN.
  - remaining cnt' > 0: go to S_FLUSH (rdy_o=0).
- S_FLUSH, on the first cycle the slot is free (!val_o | rdy_i):
  - load remainder zero-padded: LSB bits at [cnt-1:0], MSB bits at top;
  - last_o=1, bcnt_o = ceil(cnt/8)-1, done_o=1;
  - acc=0, cnt=0; return to S_RUN.
- done_o: one cycle, coincident with the final word's load (or next cycle for an empty flush).
- Boundaries:
  - total exactly DATA_WD → word emitted, cnt=0.
  - n=DATA_WD with cnt=DATA_WD-1 → total 2W-1; fits in acc, no overflow.
  - Continuous input with rdy_i=1 → one beat per cycle, no bubbles.
  - rdy_i low → output held; rdy_o low only while the slot is full.
  - val_i while rdy_o=0 → ignored; the source must hold it.
  - Reset mid-flush → all state discarded.

Decomposition:
- Shared package bs_pkg holds:
  - DATA_WD default and derived NUMB_WD/BCNT_WD;
  - state enum S_RUN/S_FLUSH;
  - function bs_mask(n) returning the low-n-bit mask.
- One natural sub-module: bs_pack_align, the combinational merge/realign of acc+code by bit order.
- FSM, counters and output register stay in bs_pack.

Test Plan:
- Scenarios 1–3 use LSB_FIRST=1, rdy_i=1; scenario 3 continues directly from scenario 2.
1. 0x409/numb 15, then 0x09040409/numb 31 → one word 0x04090409 one cycle after the second beat; cnt=16, acc=0x0904.
2. Continue: 0xF/numb 3, then 0xABCD/numb 15 → word 0xBCDF0904, bcnt 3; cnt=4, acc=0xA.
3. flush_i alone → dat_o 0x0000000A, bcnt_o 0, last_o 1, done_o 1; rdy_o low exactly one cycle.
4. LSB_FIRST=0: 0xA/numb 3, 0xB/numb 3, flush → dat_o 0xAB000000, bcnt_o 0, last_o 1.
5. rdy_i=0 for 5 cycles with a word pending → dat_o stable, rdy_o=0, no beats lost. Continuous 0xFFFFFFFF/numb 31 ×8 with random rdy_i → 8 words of 0xFFFFFFFF in order.
6. Flush with zero residual (two 16-bit codes plus flush in the second beat) → single word with last_o 1 and done_o together. Flush with cnt=0 and no val_i → no word, done_o pulse only. rstn low mid S_FLUSH → all outputs 0 immediately.
